// File: rtl/serial_word_receiver_if.sv
// serial_word_receiver_if: serial bit input, word output handshake and status flags of the receiver
interface serial_word_receiver_if #(parameter int W = 3);
  logic serial_in, bit_valid, frame_start, word_ready, clear_overrun;
  logic [W-1:0] word_out;
  logic word_valid, busy, overrun, frame_error;
  modport master (
    output serial_in, bit_valid, frame_start, word_ready, clear_overrun,
    input  word_out, word_valid, busy, overrun, frame_error
  );
  modport slave (
    input  serial_in, bit_valid, frame_start, word_ready, clear_overrun,
    output word_out, word_valid, busy, overrun, frame_error
  );
endinterface

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: assembles W-bit words from a framed serial stream into a one-word output buffer
module serial_word_receiver #(
  parameter int W = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic clk,
  input logic rst_n,
  serial_word_receiver_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic [W-1:0] sr, base, sr_nxt, word_out;
  logic word_valid, overrun, frame_error, done;
  always_comb begin
    base = bus.frame_start ? '0 : sr;
    sr_nxt = MSB_FIRST ? {base[W-2:0], bus.serial_in} : {bus.serial_in, base[W-1:1]};
    done = (state == SHIFT) && bus.bit_valid && !bus.frame_start && (cnt == CW'(W - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      word_out <= '0;
      word_valid <= 1'b0;
      overrun <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= (state == SHIFT) && bus.bit_valid && bus.frame_start;
      if (bus.bit_valid && bus.frame_start) begin
        state <= SHIFT;
        cnt <= CW'(1);
        sr <= sr_nxt;
      end else if (bus.bit_valid && state == SHIFT) begin
        sr <= sr_nxt;
        cnt <= done ? '0 : cnt + 1'b1;
        state <= done ? IDLE : SHIFT;
      end
      // a completion may refill the buffer on the same edge the held word leaves
      if (done && (!word_valid || bus.word_ready)) begin
        word_out <= sr_nxt;
        word_valid <= 1'b1;
      end else if (word_valid && bus.word_ready) begin
        word_valid <= 1'b0;
      end
      if (done && word_valid && !bus.word_ready) overrun <= 1'b1;
      else if (bus.clear_overrun) overrun <= 1'b0;
    end
  end
  assign bus.word_out = word_out;
  assign bus.word_valid = word_valid;
  assign bus.busy = (state == SHIFT);
  assign bus.overrun = overrun;
  assign bus.frame_error = frame_error;
endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver: directed and random stimulus on LSB-first and MSB-first receivers vs a bit-counting model
module tb_serial_word_receiver;
  localparam int W = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic si = 1'b0, bv = 1'b0, fs = 1'b0, wr = 1'b0, co = 1'b0;
  int checks = 0, failures = 0;
  int m_fr[2], m_cnt[2], m_acc[2], m_word[2], m_val[2], m_ovr[2], m_fe[2];

  serial_word_receiver_if #(.W(W)) bus0 ();
  serial_word_receiver_if #(.W(W)) bus1 ();

  assign bus0.serial_in = si;
  assign bus0.bit_valid = bv;
  assign bus0.frame_start = fs;
  assign bus0.word_ready = wr;
  assign bus0.clear_overrun = co;
  assign bus1.serial_in = si;
  assign bus1.bit_valid = bv;
  assign bus1.frame_start = fs;
  assign bus1.word_ready = wr;
  assign bus1.clear_overrun = co;

  serial_word_receiver #(.W(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bus0));
  serial_word_receiver #(.W(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_fr[i] = 0; m_cnt[i] = 0; m_acc[i] = 0;
      m_word[i] = 0; m_val[i] = 0; m_ovr[i] = 0; m_fe[i] = 0;
    end
  endtask

  // word value built arithmetically from the bits received in the current frame
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit done;
      int nw;
      done = 1'b0;
      nw = 0;
      m_fe[i] = (bv && fs && m_fr[i] != 0) ? 1 : 0;
      if (bv && (fs || m_fr[i] != 0)) begin
        if (fs) begin m_cnt[i] = 0; m_acc[i] = 0; end
        m_acc[i] = (i == 1) ? m_acc[i] * 2 + int'(si) : m_acc[i] + (int'(si) << m_cnt[i]);
        m_cnt[i]++;
        m_fr[i] = 1;
        if (m_cnt[i] == W) begin
          done = 1'b1; nw = m_acc[i];
          m_fr[i] = 0; m_cnt[i] = 0; m_acc[i] = 0;
        end
      end
      if (done && m_val[i] != 0 && !wr) m_ovr[i] = 1;
      else if (co) m_ovr[i] = 0;
      if (done && (m_val[i] == 0 || wr)) begin m_word[i] = nw; m_val[i] = 1; end
      else if (m_val[i] != 0 && wr) m_val[i] = 0;
    end
  endtask

  task automatic cmp();
    chk("lsb.word_out", 32'(bus0.word_out), 32'(m_word[0]));
    chk("lsb.word_valid", 32'(bus0.word_valid), 32'(m_val[0]));
    chk("lsb.busy", 32'(bus0.busy), 32'(m_fr[0]));
    chk("lsb.overrun", 32'(bus0.overrun), 32'(m_ovr[0]));
    chk("lsb.frame_error", 32'(bus0.frame_error), 32'(m_fe[0]));
    chk("msb.word_out", 32'(bus1.word_out), 32'(m_word[1]));
    chk("msb.word_valid", 32'(bus1.word_valid), 32'(m_val[1]));
    chk("msb.busy", 32'(bus1.busy), 32'(m_fr[1]));
    chk("msb.overrun", 32'(bus1.overrun), 32'(m_ovr[1]));
    chk("msb.frame_error", 32'(bus1.frame_error), 32'(m_fe[1]));
  endtask

  task automatic cyc(input logic s, input logic b, input logic f, input logic r, input logic c);
    si = s; bv = b; fs = f; wr = r; co = c;
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
    cmp();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    cmp();
    rst_n = 1'b1;
    // 1) 0x5 LSB-first back to back
    cyc(1, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0);
    chk("t1.valid_before", 32'(bus0.word_valid), 32'd0);
    cyc(1, 1, 0, 1, 0);
    chk("t1.word", 32'(bus0.word_out), 32'h5);
    chk("t1.valid", 32'(bus0.word_valid), 32'd1);
    cyc(0, 0, 0, 1, 0);
    chk("t1.valid_drop", 32'(bus0.word_valid), 32'd0);
    // 2) same word with gaps
    cyc(1, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t2.busy_gap", 32'(bus0.busy), 32'd1);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    chk("t2.word", 32'(bus0.word_out), 32'h5);
    chk("t2.busy_done", 32'(bus0.busy), 32'd0);
    cyc(0, 0, 0, 1, 0);
    // 3) overrun with word_ready low
    cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("t3.word_held", 32'(bus0.word_out), 32'h6);
    chk("t3.overrun", 32'(bus0.overrun), 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t3.overrun_clr", 32'(bus0.overrun), 32'd0);
    cyc(0, 0, 0, 1, 0);
    chk("t3.valid_drop", 32'(bus0.word_valid), 32'd0);
    // 4) aborted frame then 0x3
    cyc(1, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(1, 1, 1, 1, 0);
    chk("t4.frame_error", 32'(bus0.frame_error), 32'd1);
    cyc(1, 1, 0, 1, 0);
    chk("t4.frame_error_end", 32'(bus0.frame_error), 32'd0);
    cyc(0, 1, 0, 1, 0);
    chk("t4.word", 32'(bus0.word_out), 32'h3);
    cyc(0, 0, 0, 1, 0);
    // 5) MSB-first 0x4, then unframed bits ignored
    cyc(1, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    chk("t5.msb_word", 32'(bus1.word_out), 32'h4);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    chk("t5.ignored_valid", 32'(bus1.word_valid), 32'd0);
    chk("t5.ignored_busy", 32'(bus1.busy), 32'd0);
    // 6) mid-frame reset then 0x7
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp();
    cyc(1, 1, 0, 1, 0);
    rst_n = 1'b1;
    cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    chk("t6.word", 32'(bus0.word_out), 32'h7);
    chk("t6.overrun", 32'(bus0.overrun), 32'd0);
    // random traffic
    for (int n = 0; n < 400; n++)
      cyc(1'($urandom), ($urandom % 4) != 0, ($urandom % 6) == 0,
          1'($urandom), ($urandom % 8) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
